// File: rtl/calc2_port_driver.sv
// Drives one calc2 port: accepts requests, issues them over two cycles with a tag, and matches responses.
// Optional per-tag response timeout enabled by defining CALC2_DRV_TIMEOUT_EN.
module calc2_port_driver (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  input  logic [1:0]  resp_tag_in,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic [2:0]  outstanding,
  output logic        err_spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

  state_t      state;
  logic [3:0]  busy;
  logic [31:0] op2_q;
  logic        accept;
  logic [1:0]  free_tag;
  logic [3:0]  alloc_set;
  logic        resp_hit;
  logic        resp_spur;
  logic [3:0]  resp_clr;
  logic [3:0]  to_clr;
  logic        to_fire;
  logic [1:0]  to_tag;
  logic [3:0]  busy_next;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign in_ready = (state == IDLE) && (busy != 4'hf) && !reset;
  assign accept   = in_valid && in_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    free_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy[i]) free_tag = 2'(i);
    end
  end

  // Allocation and response matching both look at the registered busy vector, so a freed tag is reusable only next cycle.
  assign alloc_set = accept ? (4'b0001 << free_tag) : 4'b0000;
  assign resp_hit  = (resp_in != 2'b00) && busy[resp_tag_in];
  assign resp_spur = (resp_in != 2'b00) && !busy[resp_tag_in];
  assign resp_clr  = resp_hit ? (4'b0001 << resp_tag_in) : 4'b0000;

`ifdef CALC2_DRV_TIMEOUT_EN
  logic [7:0] cnt [4];
  logic [3:0] expired;

  // A real response owns the rsp slot; expired tags wait, lowest tag first.
  always_comb begin
    expired = 4'b0000;
    to_fire = 1'b0;
    to_tag  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      expired[i] = busy[i] && (cnt[i] == 8'hff) && !resp_clr[i];
    end
    for (int i = 3; i >= 0; i--) begin
      if (expired[i]) to_tag = 2'(i);
    end
    to_fire = !resp_hit && (expired != 4'b0000);
  end

  assign to_clr = to_fire ? (4'b0001 << to_tag) : 4'b0000;

  always_ff @(posedge c_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)                           cnt[i] <= 8'd0;
      else if (alloc_set[i])               cnt[i] <= 8'd0;
      else if (busy[i] && cnt[i] != 8'hff) cnt[i] <= cnt[i] + 8'd1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign to_tag  = 2'd0;
  assign to_clr  = 4'b0000;
`endif

  assign busy_next = (busy & ~resp_clr & ~to_clr) | alloc_set;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 4'b0000;
      op2_q        <= 32'd0;
      req_cmd_out  <= 4'd0;
      req_data_out <= 32'd0;
      req_tag_out  <= 2'd0;
      rsp_valid    <= 1'b0;
      rsp_status   <= 2'b00;
      rsp_data     <= 32'd0;
      rsp_tag      <= 2'd0;
      outstanding  <= 3'd0;
      err_spurious <= 1'b0;
    end else begin
      busy        <= busy_next;
      outstanding <= popcount4(busy_next);
      rsp_valid   <= 1'b0;

      if (resp_hit) begin
        rsp_valid  <= 1'b1;
        rsp_status <= resp_in;
        rsp_data   <= resp_data_in;
        rsp_tag    <= resp_tag_in;
      end else if (to_fire) begin
        rsp_valid  <= 1'b1;
        rsp_status <= 2'b11;
        rsp_data   <= 32'd0;
        rsp_tag    <= to_tag;
      end

      if (resp_spur) err_spurious <= 1'b1;

      unique case (state)
        IDLE: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= 32'd0;
          req_tag_out  <= 2'd0;
          if (accept) begin
            op2_q        <= in_op2;
            req_cmd_out  <= in_cmd;
            req_data_out <= in_op1;
            req_tag_out  <= free_tag;
            state        <= ISSUE1;
          end
        end
        ISSUE1: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= op2_q;
          state        <= ISSUE2;
        end
        ISSUE2: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= 32'd0;
          req_tag_out  <= 2'd0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc2_port_driver.sv
// Directed self-checking bench for calc2_port_driver; timeout scenario runs only with CALC2_DRV_TIMEOUT_EN.
module tb_calc2_port_driver;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  resp_in;
  logic [31:0] resp_data_in;
  logic [1:0]  resp_tag_in;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic [2:0]  outstanding;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  calc2_port_driver dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cmd       (in_cmd),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .req_tag_out  (req_tag_out),
    .resp_in      (resp_in),
    .resp_data_in (resp_data_in),
    .resp_tag_in  (resp_tag_in),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .outstanding  (outstanding),
    .err_spurious (err_spurious)
  );

  always #5 c_clk = ~c_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] t);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_cmd   = c;
    in_op1   = a;
    in_op2   = b;
    tick();
    in_valid = 1'b0;
    t = req_tag_out;
    tick();
    tick();
  endtask

  task automatic respond(input logic [1:0] s, input logic [31:0] d, input logic [1:0] t);
    resp_in      = s;
    resp_data_in = d;
    resp_tag_in  = t;
    tick();
    resp_in      = 2'b00;
    resp_data_in = 32'd0;
    resp_tag_in  = 2'd0;
  endtask

  initial begin
    logic [1:0] t;

    reset = 1'b1; in_valid = 1'b0; in_cmd = 4'd0; in_op1 = 32'd0; in_op2 = 32'd0;
    resp_in = 2'b00; resp_data_in = 32'd0; resp_tag_in = 2'd0;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outstanding", {29'd0, outstanding}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_cmd", {28'd0, req_cmd_out}, 32'd0);
    check("rst_err", {31'd0, err_spurious}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic add: two-beat issue, then matching response
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd5; in_op2 = 32'd7;
    tick();
    in_valid = 1'b0;
    check("iss1_cmd", {28'd0, req_cmd_out}, 32'd1);
    check("iss1_data", req_data_out, 32'd5);
    check("iss1_tag", {30'd0, req_tag_out}, 32'd0);
    check("iss1_ready", {31'd0, in_ready}, 32'd0);
    check("iss1_outst", {29'd0, outstanding}, 32'd1);
    tick();
    check("iss2_cmd", {28'd0, req_cmd_out}, 32'd0);
    check("iss2_data", req_data_out, 32'd7);
    check("iss2_tag", {30'd0, req_tag_out}, 32'd0);
    tick();
    check("idle_cmd", {28'd0, req_cmd_out}, 32'd0);
    check("idle_data", req_data_out, 32'd0);
    respond(2'b01, 32'd12, 2'd0);
    check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("add_rsp_status", {30'd0, rsp_status}, 32'd1);
    check("add_rsp_data", rsp_data, 32'd12);
    check("add_rsp_tag", {30'd0, rsp_tag}, 32'd0);
    check("add_outst", {29'd0, outstanding}, 32'd0);
    tick();
    check("add_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

    // Fill all four tags, free tag 2, reallocate it
    for (int i = 0; i < 4; i++) begin
      issue(4'd1, 32'(i), 32'd0, t);
      check("fill_tag", {30'd0, t}, 32'(i));
    end
    check("full_outst", {29'd0, outstanding}, 32'd4);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    respond(2'b01, 32'h22, 2'd2);
    check("free2_ready", {31'd0, in_ready}, 32'd1);
    check("free2_outst", {29'd0, outstanding}, 32'd3);
    check("free2_rsp_tag", {30'd0, rsp_tag}, 32'd2);
    issue(4'd3, 32'd9, 32'd9, t);
    check("realloc_tag", {30'd0, t}, 32'd2);
    check("realloc_outst", {29'd0, outstanding}, 32'd4);
    for (int i = 0; i < 4; i++) respond(2'b01, 32'd0, 2'(i));
    check("drain_outst", {29'd0, outstanding}, 32'd0);

    // Same-cycle free and allocate: tags 0..2 busy, tag 0 freed while accepting -> tag 3
    for (int i = 0; i < 3; i++) issue(4'd1, 32'd0, 32'd0, t);
    in_valid = 1'b1; in_cmd = 4'd4; in_op1 = 32'd1; in_op2 = 32'd2;
    resp_in = 2'b01; resp_data_in = 32'h55; resp_tag_in = 2'd0;
    tick();
    in_valid = 1'b0; resp_in = 2'b00; resp_data_in = 32'd0;
    check("same_cyc_tag", {30'd0, req_tag_out}, 32'd3);
    check("same_cyc_rsp", {31'd0, rsp_valid}, 32'd1);
    check("same_cyc_rsp_data", rsp_data, 32'h55);
    tick();
    tick();
    for (int i = 1; i < 4; i++) respond(2'b01, 32'd0, 2'(i));
    check("drain2_outst", {29'd0, outstanding}, 32'd0);

    // Sub with calc2 error status forwarded unchanged
    issue(4'd2, 32'd0, 32'd1, t);
    respond(2'b10, 32'hffff_ffff, t);
    check("sub_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("sub_rsp_status", {30'd0, rsp_status}, 32'd2);
    check("sub_rsp_data", rsp_data, 32'hffff_ffff);
    check("sub_rsp_tag", {30'd0, rsp_tag}, {30'd0, t});

    // Spurious response on a free tag
    check("spur_pre_err", {31'd0, err_spurious}, 32'd0);
    respond(2'b01, 32'd3, 2'd3);
    check("spur_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("spur_err", {31'd0, err_spurious}, 32'd1);
    repeat (3) tick();
    check("spur_err_held", {31'd0, err_spurious}, 32'd1);
    check("spur_outst", {29'd0, outstanding}, 32'd0);

    // Reset in ISSUE1, with a response arriving in the reset cycle
    in_valid = 1'b1; in_cmd = 4'd6; in_op1 = 32'd8; in_op2 = 32'd9;
    tick();
    in_valid = 1'b0;
    check("pre_rst_cmd", {28'd0, req_cmd_out}, 32'd6);
    reset = 1'b1;
    resp_in = 2'b01; resp_tag_in = 2'd0; resp_data_in = 32'd4;
    tick();
    resp_in = 2'b00; resp_data_in = 32'd0;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_cmd", {28'd0, req_cmd_out}, 32'd0);
    check("mid_rst_outst", {29'd0, outstanding}, 32'd0);
    check("mid_rst_err", {31'd0, err_spurious}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_err", {31'd0, err_spurious}, 32'd0);

`ifdef CALC2_DRV_TIMEOUT_EN
    begin
      int n = 0;
      issue(4'd1, 32'd1, 32'd1, t);
      check("to_outst_busy", {29'd0, outstanding}, 32'd1);
      while (!rsp_valid && n < 300) begin
        tick();
        n++;
      end
      check("to_seen", {31'd0, rsp_valid}, 32'd1);
      check("to_status", {30'd0, rsp_status}, 32'd3);
      check("to_tag", {30'd0, rsp_tag}, 32'd0);
      check("to_data", rsp_data, 32'd0);
      check("to_outst", {29'd0, outstanding}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc2_port_driver.md
CALC2_PORT_DRIVER -- requirements
Module: calc2_port_driver

Interface
REQ-001 SHALL have port c_clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream request valid.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid&&in_ready.
REQ-005 SHALL have ports in_cmd, input, 4 (command), in_op1, input, 32 (operand 1), in_op2, input, 32 (operand 2).
REQ-006 SHALL have ports req_cmd_out (output, 4), req_data_out (output, 32), req_tag_out (output, 2), driving one calc2 port's req cmd/data/tag.
REQ-007 SHALL have ports resp_in (input, 2), resp_data_in (input, 32), resp_tag_in (input, 2), from the same calc2 port's out_resp/out_data/out_tag.
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_status (output, 2), rsp_data (output, 32), rsp_tag (output, 2), completed-result stream.
REQ-009 SHALL have ports outstanding (output, 3, count of busy tags 0..4) and err_spurious (output, 1, sticky).

Function
REQ-010 SHALL keep a 4-bit busy vector, one bit per tag 0..3.
REQ-011 SHALL run FSM IDLE -> ISSUE1 -> ISSUE2 -> IDLE.
REQ-012 SHALL assert in_ready only in IDLE with at least one busy bit clear.
REQ-013 SHALL, on accept, latch cmd/op1/op2, allocate the lowest-numbered free tag, set its busy bit, and enter ISSUE1.
REQ-014 SHALL, in ISSUE1, drive req_cmd_out=latched cmd, req_data_out=op1, req_tag_out=tag for exactly one cycle.
REQ-015 SHALL, in ISSUE2, drive req_cmd_out=0, req_data_out=op2, req_tag_out=tag for exactly one cycle, then return to IDLE.
REQ-016 SHALL drive req_cmd_out=0, req_data_out=0, req_tag_out=0 in IDLE.
REQ-017 SHALL issue at most one request per 3 cycles: accept, ISSUE1, ISSUE2.
REQ-018 SHALL treat resp_in!=0 as a response; resp_in=0 is idle.
REQ-019 SHALL, on a response whose tag is busy, clear that busy bit and on the next cycle present rsp_valid=1 for one cycle with rsp_status=resp_in, rsp_data=resp_data_in, rsp_tag=resp_tag_in.
REQ-020 SHALL ignore a response whose tag is not busy (no rsp_valid) and set err_spurious=1 until reset.
REQ-021 SHALL not reuse a tag freed by a response until the cycle after the response; same-cycle free and allocate uses the old busy vector.
REQ-022 SHALL have no backpressure on the rsp stream; rsp_valid is never stalled.
REQ-023 SHALL update outstanding each cycle as popcount(busy).
REQ-024 SHALL pass any 4-bit in_cmd through unchecked; calc2 reports invalid commands via resp_in.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, go to IDLE, clear busy, rsp_valid, rsp_status, rsp_data, rsp_tag, req_* outputs, outstanding, and err_spurious; in_ready=0 while reset=1.
REQ-026 SHALL abandon an issue in progress when reset occurs in ISSUE1/ISSUE2, with req_cmd_out=0 the cycle after.
REQ-027 SHALL ignore responses arriving in the reset cycle.

Configuration
REQ-028 SHALL, with CALC2_DRV_TIMEOUT_EN defined, keep an 8-bit per-tag counter cleared on allocate and incremented while busy; at count 255 the tag is freed and rsp_valid pulses with rsp_status=2'b11, rsp_data=0, rsp_tag=that tag.
REQ-029 SHALL, under CALC2_DRV_TIMEOUT_EN, give a real response priority over a timeout of the same tag in the same cycle, and emit lowest-tag timeout first when multiple expire, deferring the rest by one cycle each.
REQ-030 SHALL, without CALC2_DRV_TIMEOUT_EN, contain no counters; tags stay busy until responded.

Verification
REQ-031 SHALL cover: add cmd=1, op1=5, op2=7 -> ISSUE1 drives (1,5,tag0), ISSUE2 drives (0,7,tag0); resp 01/12/tag0 -> rsp_valid, status 01, data 12, tag 0 next cycle.
REQ-032 SHALL cover: 4 accepted requests, no responses -> tags 0,1,2,3, outstanding=4, in_ready=0; resp tag2 -> in_ready=1 next cycle, next accept gets tag 2.
REQ-033 SHALL cover: resp_in=01 with tag 3 while tag 3 free -> no rsp_valid, err_spurious=1 held until reset.
REQ-034 SHALL cover: sub cmd=2, op1=0, op2=1, calc2 returns resp=10 -> rsp_status=10 forwarded unchanged.
REQ-035 SHALL cover: reset asserted in ISSUE1 -> next cycle IDLE, busy=0, outstanding=0, req_cmd_out=0, err_spurious=0.
REQ-036 SHALL cover, with CALC2_DRV_TIMEOUT_EN: one request, no response for 255 cycles -> rsp_valid, status 11, tag 0, outstanding back to 0.
